// File: rtl/hdb_pkg.sv
// -----------------------------------------------------------------------------
// hdb_pkg
// Shared definitions for the HDB-n stream decoder:
//   - line symbol encodings (SYM_ZERO, SYM_POS, SYM_NEG, SYM_ILL)
//   - hdb_stage_t : one delay-line stage {v, data, mark, err}
//   - hdb_pol_t   : pulse polarity
// -----------------------------------------------------------------------------
package hdb_pkg;

   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b10;
   localparam logic [1:0] SYM_NEG  = 2'b01;
   localparam logic [1:0] SYM_ILL  = 2'b11;

   typedef struct packed {
      logic v;
      logic data;
      logic mark;
      logic err;
   } hdb_stage_t;

   typedef enum logic {
      POL_NEG = 1'b0,
      POL_POS = 1'b1
   } hdb_pol_t;

endpackage

// File: rtl/hdb_sym_classify.sv
// -----------------------------------------------------------------------------
// hdb_sym_classify
// Combinational classification of one incoming line symbol against the
// current polarity state.
// Ports:
//   sym_in     : line symbol (hdb_pkg SYM_* encoding)
//   has_pulse  : at least one pulse seen since reset
//   last_pol   : polarity of the last normal mark
//   is_mark    : pulse with alternating polarity (or first pulse of a stream)
//   is_v       : pulse repeating last_pol, i.e. a violation
//   is_illegal : symbol 2'b11
//   pol        : polarity of sym_in (meaningful for pulses only)
// -----------------------------------------------------------------------------
import hdb_pkg::*;

module hdb_sym_classify (
   input  logic [1:0] sym_in,
   input  logic       has_pulse,
   input  hdb_pol_t   last_pol,
   output logic       is_mark,
   output logic       is_v,
   output logic       is_illegal,
   output hdb_pol_t   pol
);

   logic pulse;

   always_comb begin
      pulse      = (sym_in == SYM_POS) || (sym_in == SYM_NEG);
      pol        = (sym_in == SYM_POS) ? POL_POS : POL_NEG;
      is_illegal = (sym_in == SYM_ILL);
      // The first pulse of a stream has no reference and is always a mark.
      is_v       = pulse && has_pulse && (pol == last_pol);
      is_mark    = pulse && !is_v;
   end

endmodule

// File: rtl/hdb_n_stream_decoder.sv
// -----------------------------------------------------------------------------
// hdb_n_stream_decoder
// HDB-n line decoder (N=3 gives HDB3). Ternary symbols enter an (N+1)-deep
// delay line; a violation pulse clears the data of itself and the N older
// stages, removing 000V / B00V substitutions. Code errors (illegal symbol,
// zero run longer than N, bad substitution) travel with their bit.
// All registers update on the falling edge of clk; rst is async active-low.
// Ports:
//   clk       : decoder clock (falling edge active)
//   rst       : asynchronous active-low reset
//   sym_in    : line symbol, 2'b10 +pulse, 2'b01 -pulse, 2'b00 zero, 2'b11 illegal
//   sym_valid : sym_in accepted on this edge
//   dec_data  : decoded NRZ bit
//   dec_valid : one-cycle pulse per decoded bit
//   dec_error : code error attached to the decoded bit
//   err_count : saturating count of errored output bits
// Optional build macro HDB_ERR_CNT_EN adds err_count and its counter.
// -----------------------------------------------------------------------------
import hdb_pkg::*;

module hdb_n_stream_decoder #(
   parameter int N     = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sym_in,
   input  logic             sym_valid,
   output logic             dec_data,
   output logic             dec_valid,
`ifdef HDB_ERR_CNT_EN
   output logic             dec_error,
   output logic [CNT_W-1:0] err_count
`else
   output logic             dec_error
`endif
);

   localparam int            ZR_W   = $clog2(N + 2);
   localparam logic [ZR_W-1:0] ZR_MAX = ZR_W'(N + 1);

   hdb_stage_t      stg      [0:N];
   hdb_stage_t      stg_next [0:N];
   logic            has_pulse;
   hdb_pol_t        last_pol;
   logic [ZR_W-1:0] zero_run;
   logic [ZR_W-1:0] zr_inc;
   logic            is_mark;
   logic            is_v;
   logic            is_illegal;
   hdb_pol_t        pol;
   logic            bad_sub;

   hdb_sym_classify u_classify (
      .sym_in     (sym_in),
      .has_pulse  (has_pulse),
      .last_pol   (last_pol),
      .is_mark    (is_mark),
      .is_v       (is_v),
      .is_illegal (is_illegal),
      .pol        (pol)
   );

   always_comb begin
      zr_inc  = (zero_run == ZR_MAX) ? ZR_MAX : zero_run + 1'b1;
      // After the shift, new s[1]..s[N-1] are old s[0]..s[N-2]; a legal
      // substitution only allows a B pulse in the oldest slot.
      bad_sub = 1'b0;
      for (int k = 1; k < N; k++) begin
         if (stg[k-1].mark) bad_sub = 1'b1;
      end

      stg_next[0].v    = 1'b1;
      stg_next[0].data = is_mark;
      stg_next[0].mark = is_mark || is_v;
      stg_next[0].err  = (is_v && bad_sub) || is_illegal ||
                         (!(is_mark || is_v) && (zr_inc == ZR_MAX));
      for (int k = 1; k <= N; k++) begin
         stg_next[k] = stg[k-1];
         if (is_v) stg_next[k].data = 1'b0;
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= N; k++) stg[k] <= '0;
         has_pulse <= 1'b0;
         last_pol  <= POL_NEG;
         zero_run  <= '0;
         dec_data  <= 1'b0;
         dec_valid <= 1'b0;
         dec_error <= 1'b0;
      end else if (sym_valid) begin
         // The oldest stage leaves before any violation clearing applies.
         dec_valid <= stg[N].v;
         dec_data  <= stg[N].data;
         dec_error <= stg[N].err;
         for (int k = 0; k <= N; k++) stg[k] <= stg_next[k];
         if (is_mark) begin
            has_pulse <= 1'b1;
            last_pol  <= pol;
         end
         zero_run <= (is_mark || is_v) ? '0 : zr_inc;
      end else begin
         dec_valid <= 1'b0;
         dec_data  <= 1'b0;
         dec_error <= 1'b0;
      end
   end

`ifdef HDB_ERR_CNT_EN
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else if (sym_valid && stg[N].v && stg[N].err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hdb_n_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_hdb_n_stream_decoder
// Directed self-checking bench for hdb_n_stream_decoder with N=3.
// Each vector lists the symbols fed, optional per-symbol valid flags and the
// hand-decoded bits/errors expected once the (N+1)-symbol latency has passed.
// -----------------------------------------------------------------------------
module tb_hdb_n_stream_decoder;

   localparam int N     = 3;
   localparam int CNT_W = 16;

   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] M = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam logic [1:0] I = 2'b11;

   logic             clk;
   logic             rst;
   logic [1:0]       sym_in;
   logic             sym_valid;
   logic             dec_data;
   logic             dec_valid;
   logic             dec_error;
`ifdef HDB_ERR_CNT_EN
   logic [CNT_W-1:0] err_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [1:0] sym_q [$];
   bit         vld_q [$];
   bit         dat_q [$];
   bit         err_q [$];

   hdb_n_stream_decoder #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .dec_data  (dec_data),
      .dec_valid (dec_valid),
`ifdef HDB_ERR_CNT_EN
      .dec_error (dec_error),
      .err_count (err_count)
`else
      .dec_error (dec_error)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Async reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #2;
      sym_valid = 1'b0;
      rst       = 1'b0;
      #1;
      check_val({tag, "/rst_valid"}, {31'd0, dec_valid}, 32'd0);
      check_val({tag, "/rst_data"},  {31'd0, dec_data},  32'd0);
      check_val({tag, "/rst_error"}, {31'd0, dec_error}, 32'd0);
`ifdef HDB_ERR_CNT_EN
      check_val({tag, "/rst_cnt"}, 32'(err_count), 32'd0);
`endif
      @(negedge clk);
      @(posedge clk);
      rst = 1'b1;
   endtask

   task automatic run_seq(input string tag);
      int acc;
      int idx;
      int nerr;
      bit v;
      acc  = 0;
      nerr = 0;
      for (int i = 0; i < err_q.size(); i++) nerr += int'(err_q[i]);
      for (int i = 0; i < sym_q.size(); i++) begin
         v = (vld_q.size() == 0) ? 1'b1 : vld_q[i];
         @(posedge clk);
         sym_in    = sym_q[i];
         sym_valid = v;
         @(negedge clk);
         #1;
         if (v) acc++;
         idx = acc - (N + 2);
         if (v && (acc > N + 1) && (idx < dat_q.size())) begin
            check_val($sformatf("%s/valid%0d", tag, idx), {31'd0, dec_valid}, 32'd1);
            check_val($sformatf("%s/data%0d",  tag, idx), {31'd0, dec_data},  {31'd0, dat_q[idx]});
            check_val($sformatf("%s/err%0d",   tag, idx), {31'd0, dec_error}, {31'd0, err_q[idx]});
         end else begin
            check_val($sformatf("%s/quiet_v%0d", tag, i), {31'd0, dec_valid}, 32'd0);
            check_val($sformatf("%s/quiet_d%0d", tag, i), {31'd0, dec_data},  32'd0);
            check_val($sformatf("%s/quiet_e%0d", tag, i), {31'd0, dec_error}, 32'd0);
         end
      end
`ifdef HDB_ERR_CNT_EN
      check_val({tag, "/cnt"}, 32'(err_count), 32'(nerr));
`endif
   endtask

   initial begin
      rst       = 1'b0;
      sym_valid = 1'b0;
      sym_in    = Z;
      #1;
      do_reset("init");

      // 000V substitution, then trailing zeros and alternating flush marks.
      sym_q = '{P, Z, Z, Z, P, M, Z, Z, Z, Z, P, M, P};
      vld_q.delete();
      dat_q = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
      err_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_seq("sub000v");
      do_reset("r1");

      // B00V substitution.
      sym_q = '{P, M, P, Z, Z, P, M, P, M, P, M};
      dat_q = '{1, 1, 0, 0, 0, 0, 1};
      err_q = '{0, 0, 0, 0, 0, 0, 0};
      run_seq("subb00v");
      do_reset("r2");

      // Illegal symbol in a zero stream.
      sym_q = '{P, Z, I, Z, M, P, M, P, M};
      dat_q = '{1, 0, 0, 0, 1};
      err_q = '{0, 0, 1, 0, 0};
      run_seq("illegal");
      do_reset("r3");

      // Zero run longer than N.
      sym_q = '{P, Z, Z, Z, Z, Z, M, P, M, P};
      dat_q = '{1, 0, 0, 0, 0, 0};
      err_q = '{0, 0, 0, 0, 1, 1};
      run_seq("zerorun");
      do_reset("r4");

      // Violation with a mark inside the substitution window.
      sym_q = '{P, M, Z, M, P, M, P, M};
      dat_q = '{0, 0, 0, 0};
      err_q = '{0, 0, 0, 1};
      run_seq("badsub");
      do_reset("r5");

      // Idle edges carry +pulses that must be ignored.
      sym_q = '{P, P, Z, P, M, P, Z, P, M, P, P, M};
      vld_q = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
      dat_q = '{1, 0, 1, 0};
      err_q = '{0, 0, 0, 0};
      run_seq("idle");
      vld_q.delete();
      do_reset("r6");

      // Reset while bits are in flight; fresh stream starts with the polarity
      // that was last seen before reset.
      sym_q = '{P, M, P, M, P, M};
      dat_q = '{1, 1};
      err_q = '{0, 0};
      run_seq("pre_rst");
      do_reset("midrun");
      sym_q = '{M, P, M, P, M};
      dat_q = '{1};
      err_q = '{0};
      run_seq("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
